// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with per-bit direction, atomic set/clear/toggle
// writes, input synchroniser and per-bit rising/falling edge interrupts.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [31:0]      addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  inout  wire  [WIDTH-1:0] gpio_pin,
  output logic             irq
);

  typedef enum logic [7:0] {
    REG_DATA    = 8'h00,
    REG_DIR     = 8'h04,
    REG_SET     = 8'h08,
    REG_CLR     = 8'h0C,
    REG_TGL     = 8'h10,
    REG_RISE_EN = 8'h14,
    REG_FALL_EN = 8'h18,
    REG_STAT    = 8'h1C
  } reg_e;

  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] stat;
  logic [WIDTH-1:0] stat_next;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] wr_d;
  logic [WIDTH-1:0] stat_clr;
  logic [WIDTH-1:0] rd_w;
  reg_e             reg_sel;
  logic             unused_bits;

  assign reg_sel     = reg_e'(addr[7:0]);
  assign wr_d        = wr_data[WIDTH-1:0];
  assign sync        = sync_q[SYNC_STAGES-1];
  assign unused_bits = ^{addr[31:8], wr_data};

  // Per-bit tristate pad drivers.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio_pin[i] = dir[i] ? dout[i] : 1'bz;
  end

  // Edge events and STAT update; a new event overrides a same-cycle W1C.
  always_comb begin
    edge_ev   = ((sync & ~prev) & rise_en) | ((~sync & prev) & fall_en);
    stat_clr  = (wr_en && reg_sel == REG_STAT) ? wr_d : '0;
    stat_next = (stat & ~stat_clr) | edge_ev;
  end

  // Synchroniser chain, edge history and interrupt flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev <= '0;
      stat <= '0;
    end else begin
      sync_q[0] <= gpio_pin;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev <= sync;
      stat <= stat_next;
    end
  end

  // Bus-writable control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      dir     <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_DATA:    dout    <= wr_d;
        REG_DIR:     dir     <= wr_d;
        REG_SET:     dout    <= dout | wr_d;
        REG_CLR:     dout    <= dout & ~wr_d;
        REG_TGL:     dout    <= dout ^ wr_d;
        REG_RISE_EN: rise_en <= wr_d;
        REG_FALL_EN: fall_en <= wr_d;
        default:     ;
      endcase
    end
  end

  // Combinational read mux, zero-extended to 32 bits.
  always_comb begin
    rd_w    = '0;
    rd_data = '0;
    case (reg_sel)
      REG_DATA:    rd_w = (dout & dir) | (sync & ~dir);
      REG_DIR:     rd_w = dir;
      REG_RISE_EN: rd_w = rise_en;
      REG_FALL_EN: rd_w = fall_en;
      REG_STAT:    rd_w = stat;
      default:     rd_w = '0;
    endcase
    rd_data[WIDTH-1:0] = rd_w;
  end

  assign irq = |stat;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: default instance plus WIDTH=32/SYNC_STAGES=3
// and WIDTH=5 instances sharing the bus address/data but with private strobes.
module tb_gpio_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        wr_en0, wr_en1, wr_en2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  wire  [7:0]  pin0;
  wire  [31:0] pin1;
  wire  [4:0]  pin2;
  logic [7:0]  ext0_en, ext0_drv;
  logic [31:0] ext1_en, ext1_drv;
  logic [4:0]  ext2_en, ext2_drv;
  int          checks;
  int          errors;

  gpio_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .addr(addr), .wr_data(wr_data),
    .rd_data(rd0), .gpio_pin(pin0), .irq(irq0)
  );

  gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .addr(addr), .wr_data(wr_data),
    .rd_data(rd1), .gpio_pin(pin1), .irq(irq1)
  );

  gpio_ctrl #(.WIDTH(5), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .addr(addr), .wr_data(wr_data),
    .rd_data(rd2), .gpio_pin(pin2), .irq(irq2)
  );

  // External pad drivers.
  for (genvar i = 0; i < 8; i++) begin : g_ext0
    assign pin0[i] = ext0_en[i] ? ext0_drv[i] : 1'bz;
  end
  for (genvar i = 0; i < 32; i++) begin : g_ext1
    assign pin1[i] = ext1_en[i] ? ext1_drv[i] : 1'bz;
  end
  for (genvar i = 0; i < 5; i++) begin : g_ext2
    assign pin2[i] = ext2_en[i] ? ext2_drv[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
    addr    = a;
    wr_data = v;
    wr_en0  = (d == 0);
    wr_en1  = (d == 1);
    wr_en2  = (d == 2);
    @(posedge clk);
    #1;
    wr_en0 = 1'b0;
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] obs;
    addr = a;
    #1;
    obs = (d == 0) ? rd0 : (d == 1) ? rd1 : rd2;
    chk(tag, obs, exp);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_en2   = 1'b0;
    addr     = '0;
    wr_data  = '0;
    ext0_en  = 8'hFF;
    ext0_drv = 8'hA5;
    ext1_en  = '1;
    ext1_drv = '0;
    ext2_en  = '1;
    ext2_drv = '0;

    // Reset with pins externally at 0xA5.
    #22;
    rst_n = 1'b1;
    tick(); tick(); tick();
    rd(0, 32'h00, 32'hA5, "rst_data");
    rd(0, 32'h04, 32'h00, "rst_dir");
    rd(0, 32'h08, 32'h00, "rst_set");
    rd(0, 32'h0C, 32'h00, "rst_clr");
    rd(0, 32'h10, 32'h00, "rst_tgl");
    rd(0, 32'h14, 32'h00, "rst_rise_en");
    rd(0, 32'h18, 32'h00, "rst_fall_en");
    rd(0, 32'h1C, 32'h00, "rst_stat");
    rd(0, 32'h20, 32'h00, "rst_unmapped");
    chk("rst_irq", {31'b0, irq0}, 32'h0);
    chk("rst_pads", {24'b0, pin0}, 32'hA5);

    // Direction and output path.
    wr(0, 32'h04, 32'h0F);
    ext0_en = 8'hF0;
    wr(0, 32'h00, 32'h3C);
    chk("pads_after_data", {24'b0, pin0}, 32'hAC);
    tick(); tick();
    rd(0, 32'h00, 32'hAC, "data_mixed");
    wr(0, 32'h08, 32'h01);
    wr(0, 32'h0C, 32'h04);
    wr(0, 32'h10, 32'h0A);
    chk("pads_after_sct", {24'b0, pin0}, 32'hA3);
    tick(); tick();
    rd(0, 32'h00, 32'hA3, "data_after_sct");
    rd(0, 32'h04, 32'h0F, "dir_readback");
    rd(0, 32'h08, 32'h00, "set_reads_zero");
    wr(0, 32'h20, 32'hFF);
    rd(0, 32'h04, 32'h0F, "unmapped_write_ignored");

    // Rising-edge interrupt on pin7, latency from edge E.
    ext0_drv = 8'h25;
    tick(); tick(); tick();
    rd(0, 32'h1C, 32'h00, "fall_without_enable");
    wr(0, 32'h14, 32'h80);
    ext0_drv = 8'hA5;
    tick();                                   // edge E
    rd(0, 32'h00, 32'h23, "rise_data_E");
    tick();                                   // edge E+1
    rd(0, 32'h00, 32'hA3, "rise_data_E1");
    rd(0, 32'h1C, 32'h00, "rise_stat_E1");
    chk("rise_irq_E1", {31'b0, irq0}, 32'h0);
    tick();                                   // edge E+2
    rd(0, 32'h1C, 32'h80, "rise_stat_E2");
    chk("rise_irq_E2", {31'b0, irq0}, 32'h1);
    wr(0, 32'h1C, 32'h80);
    chk("irq_after_w1c", {31'b0, irq0}, 32'h0);
    rd(0, 32'h1C, 32'h00, "stat_after_w1c");

    // Falling-edge masking on output pin1 (sees its own driven level).
    wr(0, 32'h14, 32'h00);
    wr(0, 32'h118, 32'h02);                   // upper address bits ignored
    rd(0, 32'h18, 32'h02, "fall_en_readback");
    wr(0, 32'h0C, 32'h02);
    tick(); tick(); tick(); tick();
    rd(0, 32'h1C, 32'h02, "pin1_fall_flag");
    wr(0, 32'h1C, 32'h02);
    wr(0, 32'h08, 32'h02);
    tick(); tick(); tick(); tick();
    rd(0, 32'h1C, 32'h00, "pin1_rise_masked");
    wr(0, 32'h10, 32'h04);
    tick(); tick(); tick(); tick();
    wr(0, 32'h10, 32'h04);
    tick(); tick(); tick(); tick();
    rd(0, 32'h1C, 32'h00, "pin2_toggle_masked");
    chk("masked_irq", {31'b0, irq0}, 32'h0);

    // STAT W1C in the same cycle the pin1 fall is flagged: set wins.
    wr(0, 32'h0C, 32'h02);                    // edge W
    tick(); tick();                           // W+1, W+2
    wr(0, 32'h1C, 32'h02);                    // W+3
    rd(0, 32'h1C, 32'h02, "set_wins_stat");
    chk("set_wins_irq", {31'b0, irq0}, 32'h1);

    // WIDTH=32, SYNC_STAGES=3: four-edge interrupt latency on all bits.
    wr(1, 32'h14, 32'hFFFF_FFFF);
    ext1_drv = '1;
    tick();                                   // edge E
    tick();                                   // E+1
    rd(1, 32'h00, 32'h0000_0000, "w32_data_E1");
    tick();                                   // E+2
    rd(1, 32'h00, 32'hFFFF_FFFF, "w32_data_E2");
    chk("w32_irq_E2", {31'b0, irq1}, 32'h0);
    tick();                                   // E+3
    rd(1, 32'h1C, 32'hFFFF_FFFF, "w32_stat_E3");
    chk("w32_irq_E3", {31'b0, irq1}, 32'h1);
    wr(1, 32'h14, 32'h0);
    wr(1, 32'h18, 32'hFFFF_FFFF);
    wr(1, 32'h1C, 32'hFFFF_FFFF);
    chk("w32_irq_cleared", {31'b0, irq1}, 32'h0);
    ext1_drv = '0;
    tick(); tick(); tick(); tick(); tick();
    rd(1, 32'h1C, 32'hFFFF_FFFF, "w32_fall_stat");

    // WIDTH=5: upper read bits are zero for every register.
    wr(2, 32'h14, 32'hFFFF_FFFF);
    wr(2, 32'h18, 32'hFFFF_FFFF);
    wr(2, 32'h04, 32'hFFFF_FFFF);
    ext2_en = '0;
    wr(2, 32'h00, 32'hFFFF_FFFF);
    tick(); tick(); tick(); tick();
    chk("w5_pads", {27'b0, pin2}, 32'h1F);
    rd(2, 32'h00, 32'h1F, "w5_data");
    rd(2, 32'h04, 32'h1F, "w5_dir");
    rd(2, 32'h08, 32'h00, "w5_set");
    rd(2, 32'h0C, 32'h00, "w5_clr");
    rd(2, 32'h10, 32'h00, "w5_tgl");
    rd(2, 32'h14, 32'h1F, "w5_rise_en");
    rd(2, 32'h18, 32'h1F, "w5_fall_en");
    rd(2, 32'h1C, 32'h1F, "w5_stat");
    chk("w5_irq", {31'b0, irq2}, 32'h1);

    // Asynchronous reset mid-operation, away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_irq0", {31'b0, irq0}, 32'h0);
    chk("async_irq1", {31'b0, irq1}, 32'h0);
    rd(0, 32'h04, 32'h00, "async_dir");
    rd(0, 32'h1C, 32'h00, "async_stat");
    rd(2, 32'h00, 32'h00, "async_w5_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised memory-mapped GPIO controller with per-bit direction, atomic set/clear/toggle writes, input synchronisation and per-bit edge interrupts. It replaces the single-direction 8-bit GPIO on the peripheral bus. It also gives the core a level interrupt line for pin events.

## Interface
- `WIDTH`, 8: number of GPIO pins, legal 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, legal 2..4.
- `clk` input 1: peripheral clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `wr_en` input 1: bus write strobe, one write per cycle it is high.
- `addr` input 32: byte address; only `addr[7:0]` is decoded.
- `wr_data` input 32: write data; bits ≥ `WIDTH` ignored.
- `rd_data` output 32: combinational read data for `addr`; bits ≥ `WIDTH` read 0.
- `gpio_pin` inout `WIDTH`: pads; bit i driven with `dout[i]` when `dir[i]`=1, else Z.
- `irq` output 1: OR of all `stat` bits.

## Operation
- Register map, by `addr[7:0]`. Unmapped offsets read 0 and ignore writes:
  - 0x00 DATA: R: bit i = `dout[i]` if `dir[i]`, else `sync[i]`. W: `dout` ← wr_data.
  - 0x04 DIR: R/W, per bit; 1 = output.
  - 0x08 SET: W1S on `dout`. Reads 0.
  - 0x0C CLR: W1C on `dout`. Reads 0.
  - 0x10 TGL: write-1-toggle on `dout`. Reads 0.
  - 0x14 RISE_EN: R/W, per-bit rising-edge interrupt enable.
  - 0x18 FALL_EN: R/W, per-bit falling-edge interrupt enable.
  - 0x1C STAT: R = pending flags. W1C.
- Synchroniser: `SYNC_STAGES` flops per bit on `gpio_pin`. `sync` is the last stage. `prev` is `sync` delayed one cycle.
- Edge detection:
  - rise[i] = `sync[i]` & ~`prev[i]`.
  - fall[i] = ~`sync[i]` & `prev[i]`.
  - `stat[i]` sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Detection applies regardless of direction. Output bits see their own driven level via the pad.
- Simultaneous event and STAT W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- Enabling RISE_EN/FALL_EN does not retro-flag earlier edges. Disabling an enable does not clear `stat`.
- Only one register is written per cycle, because the address is single. Read-modify-write hazards do not exist.

## Timing
- Reset values, asynchronous on `rst_n` low:
  - `dout`, `dir`, RISE_EN, FALL_EN, `stat`, sync chain and `prev` are all 0.
  - `gpio_pin` is all Z, `irq` is 0 and `rd_data` is 0 for every register.
- Writes take effect on the first rising edge with `wr_en`=1. The new value is visible on `rd_data` and the pads in the following cycle.
- Pin input latency:
  - A pin change meeting setup before edge E appears in DATA after edge E+SYNC_STAGES-1.
  - `stat` and `irq` assert after edge E+SYNC_STAGES. With defaults, that is 2 cycles to DATA and 3 cycles to `irq`.
- `irq` is combinational from `stat` flops and does not glitch from bus activity. It deasserts the cycle after the W1C that clears the last pending bit, unless a new event sets a bit in that cycle.
- After reset release, a high pin produces a 0→1 on `sync`. This raises no `stat` because the enables are 0.
- Reset asserted mid-operation:
  - All state clears immediately, pads go Z and `irq` drops without waiting for a clock.
- Pulses shorter than one clock may be missed. No pulse stretching is provided.

## Test plan
- Reset: drive `gpio_pin`=0xA5 externally. Hold `rst_n`=0, release, wait 3 cycles.
  - All registers read 0 except DATA=0xA5.
  - `irq`=0 and no pad is driven.
- Direction and output:
  - Write DIR=0x0F, then DATA=0x3C.
  - Pads[3:0]=0xC and pads[7:4]=Z, which reads external.
  - SET 0x01, CLR 0x04, TGL 0x0A give pads[3:0]=0x3 and DATA[3:0]=0x3.
- Rising interrupt: RISE_EN=0x80, then drive pin7 0→1 at edge E.
  - DATA[7]=1 after E+1.
  - `stat`=0x80 and `irq`=1 after E+2.
  - Write STAT=0x80, and `irq`=0 next cycle.
- Falling with masking: FALL_EN=0x02 and RISE_EN=0.
  - Pin1 1→0 sets `stat`[1].
  - Pin1 0→1 sets nothing.
  - Pin2 toggling sets nothing.
- Set wins over clear: time the STAT=0x02 W1C on the same cycle that a fall on pin1 is detected. Then `stat`[1] stays 1 and `irq` stays 1.
- Parameters:
  - WIDTH=32, SYNC_STAGES=3: the interrupt path latency is 4 cycles and all 32 bits behave identically.
  - WIDTH=5: `rd_data`[31:5]=0 for all registers.
